hazard_fwd_ctrl: RTL and testbench
==================================

// Module: hazard_fwd_ctrl
// PURPOSE
//  Sequencing controller for the decode/execute stage of the 3-stage RV32I pipeline (F/D -> X -> W).
//  Tracks destination registers of instructions in X and W and produces the rs1/rs2 forwarding selects and B_sel.
//  Detects load-use hazards and stalls F/D for one cycle while injecting a bubble into X.
//  Drives regfile write-back controls (wen/waddr/csr_load) and applies branch/jump flushes.
// PARAMETERS
//  NOP_INSTR  32'h0000_0013  instruction word injected as a bubble (addi x0,x0,0)
//  CSR_ADDR   12'h51E        CSR number whose csrrw/csrrwi in W asserts csr_load
// PORTS
//  clk        in   1   single clock, rising edge
//  reset      in   1   asynchronous, active-high
//  instr_D    in   32  instruction currently in decode
//  kill_X     in   1   taken branch/jal/jalr resolved in X this cycle
//  stall_ext  in   1   memory-side stall; freezes the whole pipeline
//  rs1_sel    out  2   0=regfile, 1=rd_X, 2=rd_W (3 never driven)
//  rs2_sel    out  2   same encoding as rs1_sel
//  B_sel      out  1   1=imm on ALU B, 0=rs2_data_sel
//  stall_FD   out  1   hold PC and F/D register
//  bubble_X   out  1   D->X register loads NOP_INSTR instead of instr_D
//  flush_FD   out  1   F/D register loads NOP_INSTR
//  wen        out  1   regfile write enable (instr in W)
//  waddr      out  5   regfile write address (instr in W)
//  csr_load   out  1   W instr is csrrw/csrrwi to CSR_ADDR
// BEHAVIOUR
//  State: X-shadow {rdX[4:0], weX, ldX}, W-shadow {rdW[4:0], weW, csrW}; all reset to 0 (async).
//  Reset values of outputs: all 0 (rs1_sel=rs2_sel=0, B_sel=0, wen=0, waddr=0, csr_load=0).
//  Decode of instr_D (comb.): uses_rs1 = R,I-alu,load,store,branch,jalr; uses_rs2 = R,store,branch.
//    writes_rd = R,I-alu,load,lui,auipc,jal,jalr,csr(rd!=0); rd==x0 never counts as a write.
//  B_sel = 0 for opcode 0110011 (R) and 1100011 (branch); 1 otherwise.
//  Forwarding: rsN_sel=1 if uses_rsN && weX && rdX==rsN && !ldX; else 2 if weW && rdW==rsN; else 0.
//    X has priority over W; rsN==x0 always selects 0.
//  Load-use: ldX && weX && rdX matches a used rs of instr_D -> stall_FD=1, bubble_X=1 for exactly 1 cycle;
//    next cycle the load is in W and the operand forwards with sel=2.
//  Flush: kill_X=1 -> flush_FD=1 and bubble_X=1; overrides load-use (stall_FD=0).
//  Shadow update each edge when !stall_ext: X<=bubble_X ? 0 : decode(instr_D); W<=X.
//  stall_ext=1: shadows hold; stall_FD forced 1, bubble_X/flush_FD forced 0; sel outputs stay valid.
//  Outputs wen/waddr/csr_load are registered from W-shadow (valid the cycle the instr is in W).
//  Latency: instr decoded in cycle n writes back (wen) in cycle n+2 absent stalls.
//  Reset mid-operation: shadows cleared immediately; no forwarding or write until new instrs flow.
// CONFIGURATION
//  HAZARD_PERF_EN defined: adds outputs stall_cnt[31:0], flush_cnt[31:0]; +1 per cycle with
//    load-use stall_FD (not stall_ext) / flush_FD; wrap at 2^32; cleared by reset.
//  Not defined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  add x5,x1,x2 then add x6,x5,x5 -> 2nd instr: rs1_sel=1, rs2_sel=1, stall_FD=0.
//  add x5; nop; sub x7,x5,x3 -> sub: rs1_sel=2, rs2_sel=0; wen=1,waddr=5 2 cycles after add decoded.
//  lw x8,0(x1); add x9,x8,x0 -> 1 cycle stall_FD=1,bubble_X=1; then rs1_sel=2.
//  lw x8 in X, kill_X=1, dependent instr in D -> flush_FD=1, stall_FD=0; no write tracked for killed instr.
//  addi x0,x0,5 then add x1,x0,x0 -> rs1_sel=rs2_sel=0, wen=0 for x0.
//  csrrw x0,0x51E,x3 reaches W -> csr_load=1 one cycle; stall_ext held 3 cycles keeps all shadows frozen.

Source files
------------

// File: rtl/hazard_fwd_ctrl.sv
// Purpose : hazard/forwarding sequencer for a 3-stage RV32I pipe (F/D -> X -> W); optional perf counters under HAZARD_PERF_EN.
// Latency : forwarding selects, B_sel and stall/bubble/flush are combinational from instr_D; wen/waddr/csr_load come from the W-shadow register (instr decoded in cycle n writes back in n+2).
// Backpressure: stall_ext freezes both shadows and holds F/D; a load-use hazard holds F/D one cycle while a bubble enters X.
//
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   instr_D [31:0]             instruction in decode
//   kill_X                     taken branch/jump resolved in X; flushes F/D and bubbles X
//   stall_ext                  memory-side stall freezing the whole pipeline
//   rs1_sel/rs2_sel [1:0]      0=regfile, 1=result in X, 2=result in W
//   B_sel                      1=immediate on ALU B, 0=forwarded rs2
//   stall_FD, bubble_X, flush_FD   pipeline register controls
//   wen, waddr [4:0], csr_load     write-back controls for the instruction in W
//   stall_cnt/flush_cnt [31:0] only when HAZARD_PERF_EN is defined
module hazard_fwd_ctrl #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter logic [11:0] CSR_ADDR  = 12'h51E
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_D,
    input  logic        kill_X,
    input  logic        stall_ext,
    output logic [1:0]  rs1_sel,
    output logic [1:0]  rs2_sel,
    output logic        B_sel,
    output logic        stall_FD,
    output logic        bubble_X,
    output logic        flush_FD,
    output logic        wen,
    output logic [4:0]  waddr,
    output logic        csr_load
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // What the hazard logic needs to remember about an instruction in X.
    typedef struct packed {
        logic [4:0] rd;     // zero whenever we is clear
        logic       we;
        logic       ld;
        logic       csr;    // csrrw/csrrwi targeting CSR_ADDR
    } stage_t;

    function automatic stage_t decode(input logic [31:0] ins);
        stage_t s;
        logic   wr;
        s = '0;
        case (ins[6:0])
            OP_R, OP_IMM, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: wr = 1'b1;
            OP_SYSTEM: wr = (ins[14:12] != 3'b000);
            default:   wr = 1'b0;
        endcase
        // x0 is never a real destination, so it never enters the shadows.
        s.we  = wr && (ins[11:7] != 5'd0);
        s.rd  = s.we ? ins[11:7] : 5'd0;
        s.ld  = (ins[6:0] == OP_LOAD);
        // funct3 001 (csrrw) and 101 (csrrwi) share the low two bits.
        s.csr = (ins[6:0] == OP_SYSTEM) && (ins[13:12] == 2'b01) && (ins[31:20] == CSR_ADDR);
        return s;
    endfunction

    stage_t     x_q;
    logic [4:0] rd_w;
    logic       we_w;
    logic       csr_w;

    logic [6:0] opcode;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       load_use;

    assign opcode = instr_D[6:0];
    assign rs1    = instr_D[19:15];
    assign rs2    = instr_D[24:20];

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            OP_R, OP_STORE, OP_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR: uses_rs1 = 1'b1;
            default: ;
        endcase
    end

    // A load in X has no data yet; its dependent must wait for it to reach W.
    assign load_use = x_q.ld && x_q.we &&
                      ((uses_rs1 && (x_q.rd == rs1)) || (uses_rs2 && (x_q.rd == rs2)));

    // X wins over W (younger result). Because x0 never sets we, rs==x0 always yields 0.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic used,
                                           input stage_t x, input logic wew, input logic [4:0] rdw);
        logic [1:0] sel;
        sel = 2'd0;
        if (rs != 5'd0) begin
            if (used && x.we && (x.rd == rs) && !x.ld)
                sel = 2'd1;
            else if (wew && (rdw == rs))
                sel = 2'd2;
        end
        return sel;
    endfunction

    always_comb begin
        rs1_sel  = 2'd0;
        rs2_sel  = 2'd0;
        B_sel    = 1'b0;
        stall_FD = 1'b0;
        bubble_X = 1'b0;
        flush_FD = 1'b0;
        if (!reset) begin
            rs1_sel = fwd_sel(rs1, uses_rs1, x_q, we_w, rd_w);
            rs2_sel = fwd_sel(rs2, uses_rs2, x_q, we_w, rd_w);
            B_sel   = !((opcode == OP_R) || (opcode == OP_BRANCH));
            if (stall_ext) begin
                // Whole pipe frozen: nothing may be injected or flushed.
                stall_FD = 1'b1;
            end else begin
                // A kill discards the dependent in D, so the load-use hold is moot.
                flush_FD = kill_X;
                bubble_X = kill_X || load_use;
                stall_FD = load_use && !kill_X;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q   <= '0;
            rd_w  <= 5'd0;
            we_w  <= 1'b0;
            csr_w <= 1'b0;
        end else if (!stall_ext) begin
            x_q   <= bubble_X ? decode(NOP_INSTR) : decode(instr_D);
            rd_w  <= x_q.rd;
            we_w  <= x_q.we;
            csr_w <= x_q.csr;
        end
    end

    assign wen      = we_w;
    assign waddr    = rd_w;
    assign csr_load = csr_w;

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (!stall_ext && load_use && !kill_X)
                stall_cnt <= stall_cnt + 32'd1;
            if (flush_FD)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Purpose : directed bench for hazard_fwd_ctrl; a pipeline-of-instruction-words model is compared every cycle, plus literal spot checks.
// Latency : inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
// Backpressure: stall_ext and load-use holds are driven explicitly by the directed sequence.
module tb_hazard_fwd_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr_D = NOP;
    logic        kill_X = 1'b0;
    logic        stall_ext = 1'b0;
    logic [1:0]  rs1_sel, rs2_sel;
    logic        B_sel, stall_FD, bubble_X, flush_FD, wen, csr_load;
    logic [4:0]  waddr;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_fwd_ctrl dut (
        .clk(clk), .reset(reset), .instr_D(instr_D), .kill_X(kill_X), .stall_ext(stall_ext),
        .rs1_sel(rs1_sel), .rs2_sel(rs2_sel), .B_sel(B_sel), .stall_FD(stall_FD),
        .bubble_X(bubble_X), .flush_FD(flush_FD), .wen(wen), .waddr(waddr), .csr_load(csr_load)
`ifdef HAZARD_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    // ---------------- instruction builders ----------------
    function automatic logic [31:0] ADD(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
        return {7'b0000000, b, a, 3'b000, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] SUB(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
        return {7'b0100000, b, a, 3'b000, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] ADDI(input logic [4:0] rd, input logic [4:0] a, input logic [11:0] imm);
        return {imm, a, 3'b000, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] LW(input logic [4:0] rd, input logic [4:0] a, input logic [11:0] imm);
        return {imm, a, 3'b010, rd, 7'b0000011};
    endfunction
    function automatic logic [31:0] SW(input logic [4:0] src, input logic [4:0] base, input logic [11:0] imm);
        return {imm[11:5], src, base, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] BEQ(input logic [4:0] a, input logic [4:0] b);
        return {7'b0000000, b, a, 3'b000, 5'b00000, 7'b1100011};
    endfunction
    function automatic logic [31:0] CSRRW(input logic [4:0] rd, input logic [11:0] csr, input logic [4:0] a);
        return {csr, a, 3'b001, rd, 7'b1110011};
    endfunction

    // ---------------- model: which architectural register does each instruction touch ----------------
    function automatic logic [4:0] m_dest(input logic [31:0] i);
        logic w;
        case (i[6:0])
            7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111: w = 1'b1;
            7'b1110011: w = (i[14:12] != 3'b000);
            default:    w = 1'b0;
        endcase
        return w ? i[11:7] : 5'd0;
    endfunction
    function automatic logic m_reads1(input logic [31:0] i);
        case (i[6:0])
            7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction
    function automatic logic m_reads2(input logic [31:0] i);
        case (i[6:0])
            7'b0110011, 7'b0100011, 7'b1100011: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction
    function automatic logic m_is_csr_target(input logic [31:0] i);
        logic [11:0] csr;
        csr = i[31:20];
        return (i[6:0] == 7'b1110011) && ((i[14:12] == 3'd1) || (i[14:12] == 3'd5)) && (csr == 12'h51E);
    endfunction

    // Pipeline of actual instruction words: slot X and slot W (valid=0 means bubble/empty).
    logic [31:0] pipe_x = NOP, pipe_w = NOP;
    logic        val_x = 1'b0, val_w = 1'b0;
    int          m_stalls = 0, m_flushes = 0;

    logic [1:0] e_rs1, e_rs2;
    logic       e_bsel, e_stall, e_bubble, e_flush, e_wen, e_csr, e_lu_hold;
    logic [4:0] e_waddr;

    always_comb begin
        logic [4:0] dx, dw, r1, r2;
        logic       lx, u1, u2, hz;
        e_rs1 = 2'd0; e_rs2 = 2'd0; e_bsel = 1'b0; e_stall = 1'b0; e_bubble = 1'b0;
        e_flush = 1'b0; e_wen = 1'b0; e_waddr = 5'd0; e_csr = 1'b0; e_lu_hold = 1'b0;
        dx = val_x ? m_dest(pipe_x) : 5'd0;
        dw = val_w ? m_dest(pipe_w) : 5'd0;
        lx = val_x && (pipe_x[6:0] == 7'b0000011);
        r1 = instr_D[19:15];
        r2 = instr_D[24:20];
        u1 = m_reads1(instr_D);
        u2 = m_reads2(instr_D);
        hz = lx && (dx != 0) && ((u1 && r1 == dx) || (u2 && r2 == dx));
        if (!reset) begin
            if (r1 != 0) e_rs1 = (u1 && dx == r1 && !lx) ? 2'd1 : (dw == r1) ? 2'd2 : 2'd0;
            if (r2 != 0) e_rs2 = (u2 && dx == r2 && !lx) ? 2'd1 : (dw == r2) ? 2'd2 : 2'd0;
            e_bsel    = (instr_D[6:0] != 7'b0110011) && (instr_D[6:0] != 7'b1100011);
            e_stall   = stall_ext || (hz && !kill_X);
            e_bubble  = !stall_ext && (hz || kill_X);
            e_flush   = !stall_ext && kill_X;
            e_lu_hold = !stall_ext && hz && !kill_X;
            e_wen     = (dw != 0);
            e_waddr   = dw;
            e_csr     = val_w && m_is_csr_target(pipe_w);
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            val_x <= 1'b0; val_w <= 1'b0; m_stalls <= 0; m_flushes <= 0;
        end else begin
            if (e_lu_hold) m_stalls <= m_stalls + 1;
            if (e_flush)   m_flushes <= m_flushes + 1;
            if (!stall_ext) begin
                pipe_w <= pipe_x;
                val_w  <= val_x;
                pipe_x <= instr_D;
                val_x  <= !e_bubble;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("rs1_sel", int'(rs1_sel), int'(e_rs1));
        chk("rs2_sel", int'(rs2_sel), int'(e_rs2));
        chk("B_sel", int'(B_sel), int'(e_bsel));
        chk("stall_FD", int'(stall_FD), int'(e_stall));
        chk("bubble_X", int'(bubble_X), int'(e_bubble));
        chk("flush_FD", int'(flush_FD), int'(e_flush));
        chk("wen", int'(wen), int'(e_wen));
        chk("waddr", int'(waddr), int'(e_waddr));
        chk("csr_load", int'(csr_load), int'(e_csr));
    end

    // Drive one cycle of inputs, then return just after the falling edge of that cycle.
    task automatic cyc(input logic [31:0] ins, input logic k, input logic s);
        @(posedge clk);
        #1;
        instr_D = ins; kill_X = k; stall_ext = s;
        @(negedge clk);
        #1;
    endtask

    initial begin
        @(negedge clk); #1;
        chk("lit_rst_bsel", int'(B_sel), 0);
        chk("lit_rst_wen", int'(wen), 0);
        chk("lit_rst_rs1", int'(rs1_sel), 0);
        @(posedge clk); #1 reset = 1'b0;

        // X forwarding of both operands
        cyc(ADD(5, 1, 2), 0, 0);
        cyc(ADD(6, 5, 5), 0, 0);
        chk("lit_fx_rs1", int'(rs1_sel), 1);
        chk("lit_fx_rs2", int'(rs2_sel), 1);
        chk("lit_fx_stall", int'(stall_FD), 0);
        cyc(NOP, 0, 0);
        cyc(NOP, 0, 0);

        // W forwarding and write-back timing
        cyc(ADD(5, 1, 2), 0, 0);
        cyc(NOP, 0, 0);
        cyc(SUB(7, 5, 3), 0, 0);
        chk("lit_fw_rs1", int'(rs1_sel), 2);
        chk("lit_fw_rs2", int'(rs2_sel), 0);
        chk("lit_fw_wen", int'(wen), 1);
        chk("lit_fw_waddr", int'(waddr), 5);
        cyc(SW(7, 6, 12'd4), 0, 0);
        chk("lit_sw_rs2", int'(rs2_sel), 1);
        chk("lit_sw_bsel", int'(B_sel), 1);
        cyc(BEQ(7, 7), 0, 0);
        chk("lit_beq_rs1", int'(rs1_sel), 2);
        chk("lit_beq_bsel", int'(B_sel), 0);
        cyc(NOP, 0, 0);
        cyc(NOP, 0, 0);

        // Load-use: one stall cycle then W forwarding
        cyc(LW(8, 1, 12'd0), 0, 0);
        cyc(ADD(9, 8, 0), 0, 0);
        chk("lit_lu_stall", int'(stall_FD), 1);
        chk("lit_lu_bubble", int'(bubble_X), 1);
        cyc(ADD(9, 8, 0), 0, 0);
        chk("lit_lu_stall2", int'(stall_FD), 0);
        chk("lit_lu_rs1", int'(rs1_sel), 2);
        cyc(NOP, 0, 0);
        cyc(NOP, 0, 0);

        // Kill overrides load-use; killed instruction never writes
        cyc(LW(8, 1, 12'd0), 0, 0);
        cyc(ADD(9, 8, 8), 1, 0);
        chk("lit_kill_flush", int'(flush_FD), 1);
        chk("lit_kill_stall", int'(stall_FD), 0);
        chk("lit_kill_bubble", int'(bubble_X), 1);
        cyc(NOP, 0, 0);
        chk("lit_kill_ldwen", int'(waddr), 8);
        cyc(NOP, 0, 0);
        chk("lit_kill_nowen", int'(wen), 0);

        // x0 never forwards or writes
        cyc(ADDI(0, 0, 12'd5), 0, 0);
        cyc(ADD(1, 0, 0), 0, 0);
        chk("lit_x0_rs1", int'(rs1_sel), 0);
        chk("lit_x0_rs2", int'(rs2_sel), 0);
        cyc(NOP, 0, 0);
        chk("lit_x0_wen", int'(wen), 0);

        // csr_load for the target CSR only
        cyc(CSRRW(0, 12'h51E, 3), 0, 0);
        cyc(NOP, 0, 0);
        cyc(NOP, 0, 0);
        chk("lit_csr_load", int'(csr_load), 1);
        cyc(NOP, 0, 0);
        chk("lit_csr_drop", int'(csr_load), 0);
        cyc(CSRRW(4, 12'h300, 3), 0, 0);
        cyc(NOP, 0, 0);
        cyc(NOP, 0, 0);
        chk("lit_csr_other", int'(csr_load), 0);
        chk("lit_csr_wen", int'(wen), 1);

        // External stall freezes shadows for 3 cycles
        cyc(ADD(11, 1, 1), 0, 0);
        cyc(SUB(12, 11, 0), 0, 1);
        chk("lit_se_stall", int'(stall_FD), 1);
        chk("lit_se_rs1", int'(rs1_sel), 1);
        cyc(SUB(12, 11, 0), 1, 1);
        chk("lit_se_flush", int'(flush_FD), 0);
        chk("lit_se_bubble", int'(bubble_X), 0);
        cyc(SUB(12, 11, 0), 0, 1);
        chk("lit_se_rs1b", int'(rs1_sel), 1);
        chk("lit_se_wen", int'(wen), 0);
        cyc(SUB(12, 11, 0), 0, 0);
        cyc(NOP, 0, 0);
        chk("lit_se_wb", int'(waddr), 11);

        // Asynchronous reset in the middle of a dependency
        cyc(ADD(13, 1, 1), 0, 0);
        @(posedge clk);
        #1 instr_D = ADD(14, 13, 0);
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        @(negedge clk); #1;
        chk("lit_mr_rs1", int'(rs1_sel), 0);
        cyc(NOP, 0, 0);
        chk("lit_mr_wen", int'(wen), 0);
        cyc(NOP, 0, 0);
        cyc(NOP, 0, 0);

`ifdef HAZARD_PERF_EN
        chk("stall_cnt", int'(stall_cnt), m_stalls);
        chk("flush_cnt", int'(flush_cnt), m_flushes);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
